// File: rtl/sh4a_rf_write_sched_pkg.sv
// rtl/sh4a_rf_write_sched_pkg.sv - shared types and constant-index helpers for the RF write scheduler
`include "sh4a_registers.vh"

package sh4a_rf_write_sched_pkg;

   typedef logic [5:0]  reg_idx_t;
   typedef logic [31:0] reg_data_t;

   localparam int       NUM_REGS    = 64;
   localparam reg_idx_t CONST_IDX_0 = `REG_CONST_0;
   localparam reg_idx_t CONST_IDX_1 = `REG_CONST_1;

   // Constant registers are hardwired in the file: never written, never reserved.
   function automatic logic is_const_idx(input reg_idx_t idx);
      return (idx == CONST_IDX_0) || (idx == CONST_IDX_1);
   endfunction

endpackage

// File: rtl/sh4a_registers.vh
// rtl/sh4a_registers.vh - shared SH4A register-file index constants
`ifndef SH4A_REGISTERS_VH
`define SH4A_REGISTERS_VH

`define REG_CONST_0 6'd62
`define REG_CONST_1 6'd63

`endif

// File: rtl/sh4a_rr_arbiter.sv
// rtl/sh4a_rr_arbiter.sv - round-robin one-hot grant with its own priority pointer
module sh4a_rr_arbiter #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] win;
   logic          found;

   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int offs);
      int s;
      s = int'(base) + offs;
      if (s >= N) s = s - N;
      return PW'(s);
   endfunction

   // Scan from the pointer upward; the first requester found wins.
   always_comb begin
      grant = '0;
      win   = ptr;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && req[wrap_add(ptr, k)]) begin
            found = 1'b1;
            win   = wrap_add(ptr, k);
         end
      end
      if (found) grant[win] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (advance && found) begin
         ptr <= wrap_add(win, 1);
      end
   end

endmodule

// File: rtl/sh4a_rf_write_sched.sv
// rtl/sh4a_rf_write_sched.sv - register-file write-port scheduler with RAW/WAW scoreboard
module sh4a_rf_write_sched
   import sh4a_rf_write_sched_pkg::*;
#(
   parameter int NREQ = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [6*NREQ-1:0]  req_idx,
   input  logic [32*NREQ-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   output logic [5:0]         rf_idx_write,
   output logic [31:0]        rf_reg_write,
   output logic               rf_reg_write_enable,
   input  logic               iss_valid,
   input  logic [5:0]         iss_idx,
   output logic               iss_ok,
   input  logic [5:0]         chk_idx0,
   input  logic [5:0]         chk_idx1,
   output logic               chk_busy
);

   logic [NREQ-1:0]     grant;
   logic                grant_any;
   logic                arb_advance;
   reg_idx_t            gnt_idx;
   reg_data_t           gnt_data;
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_next;

   assign arb_advance = !reset;

   sh4a_rr_arbiter #(.N(NREQ)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req_valid),
      .advance (arb_advance),
      .grant   (grant)
   );

   assign req_ready = reset ? '0 : grant;
   assign grant_any = |req_ready;

   always_comb begin
      gnt_idx  = '0;
      gnt_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            gnt_idx  = req_idx[6*i +: 6];
            gnt_data = req_data[32*i +: 32];
         end
      end
   end

   assign iss_ok   = !busy[iss_idx];
   assign chk_busy = busy[chk_idx0] | busy[chk_idx1];

   // Set is applied after clear so a same-cycle reservation supersedes the retiring write.
   always_comb begin
      busy_next = busy;
      if (grant_any) busy_next[gnt_idx] = 1'b0;
      if (iss_valid && iss_ok && !is_const_idx(iss_idx)) busy_next[iss_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy                <= '0;
         rf_idx_write        <= '0;
         rf_reg_write        <= '0;
         rf_reg_write_enable <= 1'b0;
      end else begin
         busy                <= busy_next;
         rf_reg_write_enable <= grant_any && !is_const_idx(gnt_idx);
         if (grant_any) begin
            rf_idx_write <= gnt_idx;
            rf_reg_write <= gnt_data;
         end
      end
   end

endmodule

// File: doc/sh4a_rf_write_sched.md
# sh4a_rf_write_sched

Write-port scheduler and scoreboard for the SH4A register file. Shares the file's single write port between `NREQ` writeback requesters using round-robin arbitration with a valid/ready handshake. Tracks which of the 64 register indices have an outstanding writer, so issue logic can stall on read-after-write and write-after-write hazards. Sits between the execution/load units and the register file write port (`idx_write`, `reg_write`, `reg_write_enable`).

## Interface
- `NREQ`, default 3: number of writeback requesters; minimum 2.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NREQ  requester i holds a pending write.
- `req_idx`  in  6*NREQ  destination index; requester i uses bits [6i+5:6i].
- `req_data`  in  32*NREQ  write data; requester i uses bits [32i+31:32i].
- `req_ready`  out  NREQ  one-hot grant; the handshake completes when `req_valid[i]` and `req_ready[i]` are both high.
- `rf_idx_write`  out  6  registered; drives the register file write index.
- `rf_reg_write`  out  32  registered; drives the register file write data.
- `rf_reg_write_enable`  out  1  registered; drives the register file write enable.
- `iss_valid`  in  1  issue logic requests to reserve destination `iss_idx`.
- `iss_idx`  in  6  destination index being reserved.
- `iss_ok`  out  1  combinational; the reservation may be accepted (no WAW conflict).
- `chk_idx0`, `chk_idx1`  in  6 each  source indices of the instruction being issued.
- `chk_busy`  out  1  combinational; at least one source index has an outstanding writer.

## Operation
- Arbitration: a round-robin pointer `rr_ptr` (0..NREQ-1) marks the highest-priority requester.
  - The grant goes to the first `i` with `req_valid[i]` set, scanning `rr_ptr`, `rr_ptr+1`, … modulo NREQ.
  - `req_ready` is combinational and at most one-hot; it is zero when no `req_valid` bit is set.
  - After a grant to requester `i`, `rr_ptr` becomes `(i+1) mod NREQ`. With no grant, `rr_ptr` is unchanged.
- Write issue: a grant in cycle N registers `rf_idx_write` and `rf_reg_write` from the granted requester. `rf_reg_write_enable` goes high in cycle N+1.
- Constant indices: a granted write to REG_CONST_0 or REG_CONST_1 is still handshaken (ready asserted, requester released). `rf_reg_write_enable` stays 0 for that write.
- Scoreboard: `busy[63:0]`, one bit per index.
  - Set: an accepted issue (`iss_valid && iss_ok`) sets `busy[iss_idx]` on the next edge.
  - Clear: a grant clears `busy[req_idx of grantee]` on the next edge.
  - Same index set and cleared in one cycle: set wins, because the new reservation supersedes the old one.
  - Constant indices are never set; `busy` bits for them read 0.
- `iss_ok` = `!busy[iss_idx]`. It is 1 for constant indices.
- `chk_busy` = `busy[chk_idx0] | busy[chk_idx1]`, using the registered `busy` only. There is no bypass from a same-cycle grant, so the check is conservative.
- Writes without a prior reservation are legal. A clear of a non-busy bit has no effect.

## Timing
- Reset values: `rr_ptr`=0, `busy`=0, `rf_idx_write`=0, `rf_reg_write`=0, `rf_reg_write_enable`=0.
- Grant-to-write latency: 1 cycle.
- Throughput: 1 write per cycle sustained.
- `busy` visible on `chk_busy`/`iss_ok`: 1 cycle after the issue is accepted.
- `busy` clears visibly 1 cycle after the grant, which is the same cycle `rf_reg_write_enable` is high.
- Reset asserted mid-operation:
  - All reservations and pending state are dropped.
  - `rf_reg_write_enable` is 0 in the cycle after any reset cycle, even if a grant occurred in the same cycle as reset.
  - `req_ready` is forced to 0 while reset is high.
- A requester must keep `req_valid`, `req_idx` and `req_data` stable until it is granted. No fairness bound is needed beyond round-robin: worst-case wait is NREQ-1 grants.

## Structure
- REG_CONST_0 and REG_CONST_1 index constants come from the shared `sh4a_registers.vh` header. No local redefinition.
- One sub-module: `sh4a_rr_arbiter`, a parameterized round-robin grant with its pointer register. It takes `req`, an `advance` enable and `reset`, and outputs a one-hot `grant`.
- The top level holds the output registers, the scoreboard and the constant-index filtering.

## Test plan
- All three requesters valid continuously (idx 1, 2, 3; data 0x11, 0x22, 0x33) from reset → grants in order 0,1,2,0,…. `rf_reg_write_enable`=1 every cycle from the cycle after the first grant, with (1,0x11), (2,0x22), (3,0x33), … following one cycle after each grant.
- Requester 1 only, idx 5, data 0xDEADBEEF → `req_ready`=3'b010 in cycle N. In N+1: `rf_idx_write`=5, `rf_reg_write`=0xDEADBEEF, enable=1.
- Requester 0 writes REG_CONST_0 → `req_ready[0]`=1; enable stays 0 in the next cycle.
- Issue reserves idx 7; next cycle `chk_idx0`=7 → `chk_busy`=1, and `iss_ok`=0 for idx 7. Requester 2 is then granted with idx 7 → `chk_busy`=0 one cycle after the grant.
- Same cycle: issue reserves idx 9 while requester 0 is granted with idx 9 and `busy[9]` was 0 → `busy[9]`=1 afterwards (set wins).
- Reset asserted in the same cycle as a grant to idx 4 → enable=0 next cycle, all `busy` bits 0, and `rr_ptr`=0 (requester 0 has priority on the next request).
